// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit: issue opcodes,
// sequencer states and HI/LO read-select values.
package muldiv_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MTHI  = 2'b10,
      OP_MTLO  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DIV  = 2'b10
   } state_t;

   localparam logic RD_LO = 1'b0;
   localparam logic RD_HI = 1'b1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Control-unit <-> multiply/divide unit connection.
//
// Handshake: an instruction is presented by holding start (with op, a, b)
// high. It is accepted on the first rising edge where the unit is idle
// (busy == 0); while busy, stall is raised and the control unit must keep
// start, op, a and b stable. A HI/LO read (rd_req) is valid only in a cycle
// where stall is low; rd_data is combinational from the selected register.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   import muldiv_sequencer_pkg::*;

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             rd_req;
   logic             rd_sel;
   logic [WIDTH-1:0] rd_data;
   logic             busy;
   logic             stall;
   logic             done;
   logic             div_zero;
   state_t           dbg_state;

   modport master (
      output start, op, a, b, rd_req, rd_sel,
      input  rd_data, busy, stall, done, div_zero, dbg_state
   );

   modport slave (
      input  start, op, a, b, rd_req, rd_sel,
      output rd_data, busy, stall, done, div_zero, dbg_state
   );

endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the sequencer, purely combinational.
// Multiply (shift-add): the accumulator upper half collects partial sums and
// shifts right; product bits fall into the lower half. After WIDTH steps the
// accumulator holds the full 2*WIDTH product.
// Divide (restoring): upper half is the running remainder, lower half the
// quotient built LSB-last; in_bit supplies the next dividend bit, MSB first.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     operand,   // multiplicand or divisor
   input  logic                 in_bit,    // multiplier bit or dividend bit
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   // Single add-shift or subtract-restore step selected by mode
   always_comb begin
      sum      = '0;
      shifted  = '0;
      diff     = '0;
      acc_next = acc;
      if (!is_div) begin
         sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (in_bit ? {1'b0, operand} : '0);
         acc_next = {sum, acc[WIDTH-1:1]};
      end else begin
         shifted = {acc[2*WIDTH-1:WIDTH], in_bit};
         // When the subtraction is taken the result is below the divisor,
         // so the low WIDTH bits of the difference are exact.
         diff    = shifted[WIDTH-1:0] - operand;
         if (shifted >= {1'b0, operand}) begin
            acc_next = {diff, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULTU/DIVU unit owning the architectural HI/LO registers.
// One operation in flight; results commit WIDTH edges after acceptance
// (one edge for a divide by zero). Stalls consumers and new issues while busy.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   muldiv_sequencer_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   state_t             state_next;
   logic [CW-1:0]      counter;
   logic [CW-1:0]      div_idx;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] step_acc;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic               done_q;
   logic               div_zero_q;
   logic               dz_pending;
   logic               is_div;
   logic               step_bit;
   logic               last_iter;

   assign is_div    = (state == DIV);
   assign last_iter = (counter == LAST);
   // Dividend bits are consumed MSB first
   assign div_idx   = LAST - counter;
   assign step_bit  = is_div ? opa[div_idx] : opb[counter];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div   (is_div),
      .acc      (acc),
      .operand  (is_div ? opb : opa),
      .in_bit   (step_bit),
      .acc_next (step_acc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: accept MULTU/DIVU in IDLE, leave after the last iteration
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MULTU) state_next = MUL;
               else if (bus.op == OP_DIVU) state_next = DIV;
            end
         end
         MUL: begin
            if (last_iter) state_next = IDLE;
         end
         DIV: begin
            if (dz_pending || last_iter) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs: busy while sequencing, stall held-back issues and HI/LO reads
   always_comb begin
      bus.busy      = (state != IDLE);
      bus.stall     = (state != IDLE) & (bus.start | bus.rd_req);
      bus.rd_data   = (bus.rd_sel == RD_HI) ? hi : lo;
      bus.done      = done_q;
      bus.div_zero  = div_zero_q;
      bus.dbg_state = state;
   end

   // Datapath: operand latch, iteration, HI/LO commit and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         counter    <= '0;
         opa        <= '0;
         opb        <= '0;
         acc        <= '0;
         hi         <= '0;
         lo         <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         dz_pending <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     OP_MULTU: begin
                        opa     <= bus.a;
                        opb     <= bus.b;
                        acc     <= '0;
                        counter <= '0;
                     end
                     OP_DIVU: begin
                        opa        <= bus.a;
                        opb        <= bus.b;
                        acc        <= '0;
                        counter    <= '0;
                        dz_pending <= (bus.b == '0);
                        div_zero_q <= (bus.b == '0);
                     end
                     OP_MTHI: hi <= bus.a;
                     OP_MTLO: lo <= bus.a;
                     default: ;
                  endcase
               end
            end
            MUL, DIV: begin
               if (is_div && dz_pending) begin
                  // Divide by zero: no iterations, fixed result
                  lo         <= '1;
                  hi         <= opa;
                  done_q     <= 1'b1;
                  dz_pending <= 1'b0;
               end else begin
                  acc     <= step_acc;
                  counter <= counter + 1'b1;
                  if (last_iter) begin
                     hi      <= step_acc[2*WIDTH-1:WIDTH];
                     lo      <= step_acc[WIDTH-1:0];
                     done_q  <= 1'b1;
                     counter <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit owning the architectural HI/LO registers; replaces a single-cycle combinational multiply in the ALU.
- Sits beside the ALU in the datapath; the control unit issues MULTU/DIVU/MTHI/MTLO and reads HI/LO for MFHI/MFLO.
- Sequences one WIDTH-cycle shift-add multiply or restoring divide at a time.
- Raises a stall to the PC/register-file write path while a HI/LO consumer or a new issue must wait.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- start  input  1  issue request, qualified by op
- op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- rd_req  input  1  MFHI/MFLO in the current instruction
- rd_sel  input  1  0 = LO, 1 = HI
- rd_data  output  WIDTH  combinational HI or LO per rd_sel
- busy  output  1  operation in flight
- stall  output  1  freeze PC and register-file write this cycle
- done  output  1  one-cycle pulse when a multiply or divide result is committed
- div_zero  output  1  sticky flag: last DIVU had b == 0

Behaviour:
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, state = IDLE, counter = 0. Reset mid-operation aborts the operation with no partial HI/LO commit.
- States:
  - IDLE: start & op=MULTU -> MUL. start & op=DIVU -> DIV. Both latch a, b, clear the working accumulator, and set counter = 0.
  - MUL/DIV: one iteration per clock. The counter increments each cycle. Leave the state when counter == WIDTH-1.
- Timing: start sampled at edge E0, so busy = 1 after E0. Iterations run on edges E1..EWIDTH. At EWIDTH, HI/LO are written, busy falls and done = 1 for the following cycle only. Result latency from issue is therefore WIDTH cycles.
- MULTU: unsigned shift-add over a 2*WIDTH accumulator. HI = upper half, LO = lower half.
- DIVU: unsigned restoring division. LO = quotient, HI = remainder.
- DIVU with b == 0: no iteration. Commit at E1 with LO = all ones and HI = a. Set div_zero; busy lasts one cycle and done pulses after E1.
- div_zero clears on the next accepted DIVU with b != 0.
- MTHI/MTLO: accepted only in IDLE. Write at the sampling edge with no busy and no done.
- Stall rules:
  - stall = busy & (start | rd_req).
  - start while busy is ignored, and the instruction is held by stall until it is accepted in IDLE.
  - rd_data during busy returns the old HI/LO value, which is not used because stall is asserted.
- Simultaneous events:
  - In the cycle done = 1, the state is already IDLE, so a new start is accepted.
  - rd_req alongside done reads the new values without stall.
- Widths: all arithmetic is unsigned and modulo 2*WIDTH. The counter is clog2(WIDTH) bits.

Decomposition:
- Shared package: op encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO), the state enum (IDLE, MUL, DIV), and the RD_LO/RD_HI constants.
- Sub-module muldiv_step: purely combinational single-iteration step (add-shift or subtract-restore) taking the accumulator, operands and mode. The sequencer holds all registers and the FSM.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done exactly 32 cycles after the issue edge; HI=0xFFFFFFFE, LO=0x00000001.
- DIVU a=100, b=7 -> LO=14, HI=2, div_zero=0. A following DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5, div_zero=1, done after 1 cycle.
- MULTU 3*4 issued, then MFLO (rd_req=1) on the next cycle -> stall=1 for all busy cycles. With done=1, stall=0 and rd_data=12.
- Second start (DIVU 9/2) during a busy MULTU -> stall=1, the first result commits unaffected, then the DIVU is accepted in IDLE and gives LO=4, HI=1.
- MTHI a=0xDEADBEEF, then MFHI -> rd_data=0xDEADBEEF next cycle, busy stays 0.
- Reset asserted 10 cycles into a MULTU -> next cycle busy=0, HI=LO=0, done never pulses.
